led_panel_rx: RTL and testbench
===============================

LED_PANEL_RX -- requirements
Module: led_panel_rx

Interface
REQ-001 SHALL: parameter COLS, default 32, shift-register depth per row.
REQ-002 SHALL: parameter ROWS, default 4, row addresses per scan.
REQ-003 SHALL: port clk  in  1  system clock, all logic on posedge.
REQ-004 SHALL: port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL: ports sclk, latch, blank, aclk, arst  in  1 each  panel control lines, asynchronous to clk.
REQ-006 SHALL: port rgb_in  in  3  {red,green,blue} panel data, asynchronous to clk.
REQ-007 SHALL: ports rd_row in 2, rd_col in 5  readback address.
REQ-008 SHALL: port rd_rgb  out  3  stored pixel at {rd_row,rd_col}.
REQ-009 SHALL: ports row_addr out 2, lit out 1  current panel row, high when row visible (blank low).
REQ-010 SHALL: ports frame_done out 1, err out 1  one-cycle frame pulse; sticky protocol error.

Function
REQ-011 SHALL: pass every panel input through a 2-flop synchronizer; all edges detected on synchronized copies (3-cycle input-to-action latency).
REQ-012 SHALL: on sclk rising edge, shift rgb_in into three COLS-bit shift registers (new bit at index 0) and increment bit_cnt (6-bit, saturates at 63).
REQ-013 SHALL: on latch rising edge, write the three shift registers into frame memory row row_addr and clear bit_cnt next cycle.
REQ-014 SHALL: on latch rising edge with bit_cnt != COLS, still perform the write and set err.
REQ-015 SHALL: on aclk rising edge with arst low, row_addr <= row_addr+1, wrapping ROWS-1 -> 0.
REQ-016 SHALL: while arst high, hold row_addr at 0; arst overrides aclk in the same cycle.
REQ-017 SHALL: pulse frame_done one cycle on arst rising edge when all ROWS rows were latched since the previous arst rising edge (tracked by a ROWS-bit seen mask, cleared on that edge).
REQ-018 SHALL: sclk and latch rising edges in the same cycle -> shift first, then write the post-shift registers.
REQ-019 SHALL: lit = ~blank_sync, registered.
REQ-020 SHALL: rd_rgb registered, one-cycle read latency; read of row being written in same cycle returns old data.
REQ-021 SHALL: rd_col >= COLS return 3'b000.
REQ-022 SHALL: internal state machine IDLE -> SHIFT (first sclk edge) -> LATCHED (latch edge) -> IDLE (next sclk edge or arst); latch in IDLE sets err (empty latch).

Reset
REQ-023 SHALL: reset clear synchronizers to sclk=1, latch=0, blank=1, aclk=0, arst=1, so no edge fires on release.
REQ-024 SHALL: reset clear shift registers, bit_cnt, row_addr, seen mask, err, frame_done, rd_rgb, lit to 0; state IDLE.
REQ-025 SHALL: frame memory is not reset; reset mid-shift discards partial row.

Configuration
REQ-026 SHALL: macro LED_PANEL_RX_BLANK_STATS_EN, when defined, add output on_cycles[15:0], counting clk cycles with lit high, saturating at 16'hFFFF, cleared on frame_done.
REQ-027 SHALL: without LED_PANEL_RX_BLANK_STATS_EN, port on_cycles and counter absent; all other behaviour identical.

Structure
REQ-028 SHALL: shared package led_panel_pkg holds COLS/ROWS defaults, rgb index constants (RED=2, GREEN=1, BLUE=0) and state encodings.
REQ-029 SHALL: sub-module sync_edge (2-flop sync + rise detect, reset value parameter) instantiated per control input.

Verification
REQ-030 SHALL: 32 sclk edges with rgb_in=3'b101 on bits 0-7 else 0, latch, row 0 -> rd_row=0 rd_col=0..7 read 3'b101, cols 8..31 read 0, err=0.
REQ-031 SHALL: 31 sclk edges then latch -> err=1 and stays 1 until reset.
REQ-032 SHALL: four rows latched with aclk between, then arst rise -> frame_done exactly one cycle, row_addr=0.
REQ-033 SHALL: aclk and arst rising same cycle at row 2 -> row_addr=0, no increment.
REQ-034 SHALL: reset asserted after 10 sclk edges, released, 32 edges + latch -> err=0, row 0 holds only new data.
REQ-035 SHALL: with LED_PANEL_RX_BLANK_STATS_EN, blank low 100 clk cycles within one frame -> on_cycles=100 before frame_done, 0 after.

Source files
------------

// File: rtl/led_panel_pkg.sv
// ============================================================================
// Module : led_panel_pkg
// Brief  : Shared defaults, colour bit indices and receiver state encodings.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package led_panel_pkg;

  localparam int COLS_DEFAULT = 32;
  localparam int ROWS_DEFAULT = 4;

  localparam int RGB_RED   = 2;
  localparam int RGB_GREEN = 1;
  localparam int RGB_BLUE  = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_LATCHED = 2'd2
  } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/led_panel_rx_sync_edge.sv
// ============================================================================
// Module : sync_edge
// Brief  : Two-flop synchronizer with rising-edge detect on the synced copy.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_edge
  import led_panel_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise
);

  logic s1_q, s2_q, prev_q;
  logic s1_d, s2_d, prev_d;

  always_comb begin
    s1_d   = d;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  // Reset value chosen per line so that release never looks like an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= RST_VAL;
      s2_q   <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign q    = s2_q;
  assign rise = s2_q & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/led_panel_rx.sv
// ============================================================================
// Module : led_panel_rx
// Brief  : LED panel scan receiver: captures shifted rows into a frame store.
//          Optional LED_PANEL_RX_BLANK_STATS_EN adds the on_cycles counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module led_panel_rx
  import led_panel_pkg::*;
#(
  parameter int COLS = COLS_DEFAULT,
  parameter int ROWS = ROWS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        latch,
  input  logic        blank,
  input  logic        aclk,
  input  logic        arst,
  input  logic [2:0]  rgb_in,
  input  logic [1:0]  rd_row,
  input  logic [4:0]  rd_col,
  output logic [2:0]  rd_rgb,
  output logic [1:0]  row_addr,
  output logic        lit,
  output logic        frame_done,
  output logic        err
`ifdef LED_PANEL_RX_BLANK_STATS_EN
  ,
  output logic [15:0] on_cycles
`endif
);

  localparam logic [1:0] ROW_LAST = 2'(ROWS - 1);

  logic sclk_rise, latch_rise, aclk_rise, arst_rise, arst_q, blank_q;
  logic sclk_lvl_unused, latch_lvl_unused, aclk_lvl_unused, blank_rise_unused;

  sync_edge #(.RST_VAL(1'b1)) u_sync_sclk  (.clk(clk), .reset(reset), .d(sclk),
                                            .q(sclk_lvl_unused), .rise(sclk_rise));
  sync_edge #(.RST_VAL(1'b0)) u_sync_latch (.clk(clk), .reset(reset), .d(latch),
                                            .q(latch_lvl_unused), .rise(latch_rise));
  sync_edge #(.RST_VAL(1'b1)) u_sync_blank (.clk(clk), .reset(reset), .d(blank),
                                            .q(blank_q), .rise(blank_rise_unused));
  sync_edge #(.RST_VAL(1'b0)) u_sync_aclk  (.clk(clk), .reset(reset), .d(aclk),
                                            .q(aclk_lvl_unused), .rise(aclk_rise));
  sync_edge #(.RST_VAL(1'b1)) u_sync_arst  (.clk(clk), .reset(reset), .d(arst),
                                            .q(arst_q), .rise(arst_rise));

  logic [2:0]      rgb_s1_q, rgb_s2_q;
  logic [COLS-1:0] sr_q [3];
  logic [COLS-1:0] sr_d [3];
  logic [5:0]      bit_cnt_q, bit_cnt_d, cnt_shifted;
  logic [1:0]      row_addr_q, row_addr_d;
  logic [ROWS-1:0] seen_q, seen_d;
  logic            err_q, err_d, frame_done_q, frame_done_d, lit_q, lit_d;
  logic [2:0]      rd_rgb_q, rd_rgb_d;
  logic            empty_latch;
  rx_state_e       state_q, state_d;
  logic [COLS-1:0] mem_q [ROWS][3];

  always_comb begin
    state_d     = state_q;
    empty_latch = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (latch_rise) begin
          state_d     = ST_LATCHED;
          empty_latch = !sclk_rise;
        end else if (sclk_rise) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT:   if (latch_rise) state_d = ST_LATCHED;
      ST_LATCHED: if (!latch_rise && (sclk_rise || arst_rise)) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // A same-cycle latch stores and counts the post-shift contents
  always_comb begin
    sr_d        = sr_q;
    cnt_shifted = bit_cnt_q;
    if (sclk_rise) begin
      sr_d[RGB_RED]   = {sr_q[RGB_RED][COLS-2:0],   rgb_s2_q[RGB_RED]};
      sr_d[RGB_GREEN] = {sr_q[RGB_GREEN][COLS-2:0], rgb_s2_q[RGB_GREEN]};
      sr_d[RGB_BLUE]  = {sr_q[RGB_BLUE][COLS-2:0],  rgb_s2_q[RGB_BLUE]};
      if (bit_cnt_q != 6'h3F) cnt_shifted = bit_cnt_q + 6'd1;
    end
    bit_cnt_d = latch_rise ? 6'd0 : cnt_shifted;

    err_d = err_q;
    if (latch_rise && ((32'(cnt_shifted) != COLS) || empty_latch)) err_d = 1'b1;

    row_addr_d = row_addr_q;
    if (arst_q) row_addr_d = 2'd0;
    else if (aclk_rise) row_addr_d = (row_addr_q == ROW_LAST) ? 2'd0 : row_addr_q + 2'd1;

    seen_d = seen_q;
    if (latch_rise) seen_d[row_addr_q] = 1'b1;
    frame_done_d = 1'b0;
    if (arst_rise) begin
      frame_done_d = &seen_d;
      seen_d       = '0;
    end

    lit_d = ~blank_q;

    rd_rgb_d = 3'b000;
    if ((32'(rd_col) < COLS) && (32'(rd_row) < ROWS))
      rd_rgb_d = {mem_q[rd_row][RGB_RED][rd_col],
                  mem_q[rd_row][RGB_GREEN][rd_col],
                  mem_q[rd_row][RGB_BLUE][rd_col]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_s1_q     <= 3'b000;
      rgb_s2_q     <= 3'b000;
      sr_q         <= '{default: '0};
      bit_cnt_q    <= 6'd0;
      row_addr_q   <= 2'd0;
      seen_q       <= '0;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
      lit_q        <= 1'b0;
      rd_rgb_q     <= 3'b000;
      state_q      <= ST_IDLE;
    end else begin
      rgb_s1_q     <= rgb_in;
      rgb_s2_q     <= rgb_s1_q;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      row_addr_q   <= row_addr_d;
      seen_q       <= seen_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
      lit_q        <= lit_d;
      rd_rgb_q     <= rd_rgb_d;
      state_q      <= state_d;
    end
  end

  // Frame store keeps its contents across reset
  always_ff @(posedge clk) begin
    if (latch_rise) begin
      mem_q[row_addr_q][RGB_RED]   <= sr_d[RGB_RED];
      mem_q[row_addr_q][RGB_GREEN] <= sr_d[RGB_GREEN];
      mem_q[row_addr_q][RGB_BLUE]  <= sr_d[RGB_BLUE];
    end
  end

  assign rd_rgb     = rd_rgb_q;
  assign row_addr   = row_addr_q;
  assign lit        = lit_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

`ifdef LED_PANEL_RX_BLANK_STATS_EN
  logic [15:0] on_cycles_q, on_cycles_d;

  always_comb begin
    on_cycles_d = on_cycles_q;
    if (frame_done_q) on_cycles_d = 16'd0;
    else if (lit_q && (on_cycles_q != 16'hFFFF)) on_cycles_d = on_cycles_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) on_cycles_q <= 16'd0;
    else       on_cycles_q <= on_cycles_d;
  end

  assign on_cycles = on_cycles_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_led_panel_rx.sv
// ============================================================================
// Module : tb_led_panel_rx
// Brief  : Self-checking bench for led_panel_rx (read scoreboard + direct checks).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_led_panel_rx;

  localparam int COLS = 32;
  localparam int ROWS = 4;

  logic       clk = 1'b0;
  logic       reset, sclk, latch, blank, aclk, arst;
  logic [2:0] rgb_in;
  logic [1:0] rd_row;
  logic [4:0] rd_col;
  logic [2:0] rd_rgb;
  logic [1:0] row_addr;
  logic       lit, frame_done, err;
`ifdef LED_PANEL_RX_BLANK_STATS_EN
  logic [15:0] on_cycles;
`endif

  led_panel_rx #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .latch(latch), .blank(blank),
    .aclk(aclk), .arst(arst), .rgb_in(rgb_in), .rd_row(rd_row), .rd_col(rd_col),
    .rd_rgb(rd_rgb), .row_addr(row_addr), .lit(lit), .frame_done(frame_done),
    .err(err)
`ifdef LED_PANEL_RX_BLANK_STATS_EN
    , .on_cycles(on_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] row;
    logic [4:0] col;
    logic [2:0] exp;
  } rd_vec_t;

  typedef struct {
    logic [2:0] exp;
    int         due;
    logic [1:0] row;
    logic [4:0] col;
  } sb_t;

  rd_vec_t    t030[$];
  rd_vec_t    vecs[$];
  sb_t        sb[$];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [2:0] exp_mem [ROWS][COLS];
  logic [2:0] msr [COLS];
  int         mrow = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Read scoreboard: each entry is due one cycle after its address was driven
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      sb_t e;
      e = sb.pop_front();
      n_tests++;
      if (rd_rgb !== e.exp) begin
        n_fail++;
        $display("FAIL rd_rgb row=%0d col=%0d: got %b expected %b", e.row, e.col, rd_rgb, e.exp);
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] pat(input int seed, input int k);
    if (seed < 0) return (k >= 24) ? 3'b101 : 3'b000;
    return 3'((k * 3 + seed * 5 + (k >> 2)) & 7);
  endfunction

  task automatic model_shift(input logic [2:0] v);
    for (int c = COLS - 1; c > 0; c--) msr[c] = msr[c-1];
    msr[0] = v;
  endtask

  task automatic model_write();
    for (int c = 0; c < COLS; c++) exp_mem[mrow][c] = msr[c];
  endtask

  task automatic sclk_edge(input logic [2:0] v);
    rgb_in = v;
    sclk   = 1'b0;
    wait_clk(3);
    sclk   = 1'b1;
    wait_clk(3);
    model_shift(v);
  endtask

  task automatic shift_bits(input int seed, input int n);
    for (int k = 0; k < n; k++) sclk_edge(pat(seed, k));
  endtask

  task automatic latch_pulse();
    latch = 1'b1;
    wait_clk(4);
    latch = 1'b0;
    wait_clk(4);
    model_write();
  endtask

  task automatic aclk_pulse();
    aclk = 1'b1;
    wait_clk(4);
    aclk = 1'b0;
    wait_clk(4);
    mrow = (mrow + 1) % ROWS;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(4);
    for (int c = 0; c < COLS; c++) msr[c] = 3'b000;
    mrow = 0;
  endtask

  task automatic fill_row(input int r);
    for (int c = 0; c < COLS; c++) vecs.push_back('{row: 2'(r), col: 5'(c), exp: exp_mem[r][c]});
  endtask

  task automatic run_reads();
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rd_row = vecs[i].row;
      rd_col = vecs[i].col;
      sb.push_back('{exp: vecs[i].exp, due: cyc + 1, row: vecs[i].row, col: vecs[i].col});
    end
    wait_clk(3);
    vecs.delete();
  endtask

  // Latch while reading column 0 of the target row: old data on the write
  // cycle, new data one cycle later.
  task automatic latch_rdw();
    logic [2:0] oldv, newv;
    oldv   = exp_mem[mrow][0];
    newv   = msr[0];
    rd_row = 2'(mrow);
    rd_col = 5'd0;
    @(posedge clk);
    #1;
    latch = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rdw_old_data", 16'(rd_rgb), 16'(oldv));
    @(negedge clk);
    check("rdw_new_data", 16'(rd_rgb), 16'(newv));
    wait_clk(2);
    latch = 1'b0;
    wait_clk(4);
    model_write();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd;

    for (int c = 0; c < COLS; c++)
      t030.push_back('{row: 2'd0, col: 5'(c), exp: (c < 8) ? 3'b101 : 3'b000});
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) exp_mem[r][c] = 3'b000;
    for (int c = 0; c < COLS; c++) msr[c] = 3'b000;

    sclk = 1'b1; latch = 1'b0; blank = 1'b1; aclk = 1'b0; arst = 1'b1;
    rgb_in = 3'b000; rd_row = 2'd0; rd_col = 5'd0; reset = 1'b1;

    wait_clk(3);
    @(negedge clk);
    check("reset_rd_rgb", 16'(rd_rgb), 16'h0);
    check("reset_row_addr", 16'(row_addr), 16'h0);
    check("reset_err", 16'(err), 16'h0);
    check("reset_frame_done", 16'(frame_done), 16'h0);
    check("reset_lit", 16'(lit), 16'h0);
    reset = 1'b0;
    wait_clk(4);
    arst = 1'b0;
    wait_clk(4);
    check("release_err", 16'(err), 16'h0);
    check("release_row_addr", 16'(row_addr), 16'h0);

    // Row 0: 101 on the last 8 shifts lands in columns 0..7
    shift_bits(-1, 32);
    latch_pulse();
    check("row0_err", 16'(err), 16'h0);
    vecs = t030;
    run_reads();

    // Full frame with distinct data per row
    aclk_pulse();
    check("row_addr_1", 16'(row_addr), 16'h1);
    shift_bits(1, 32);
    latch_pulse();
    aclk_pulse();
    check("row_addr_2", 16'(row_addr), 16'h2);
    shift_bits(3, 32);
    latch_pulse();
    aclk_pulse();
    check("row_addr_3", 16'(row_addr), 16'h3);
    shift_bits(4, 32);
    latch_pulse();
    check("frame_err", 16'(err), 16'h0);

    blank = 1'b0;
    wait_clk(5);
    check("lit_on", 16'(lit), 16'h1);
    wait_clk(95);
    blank = 1'b1;
    wait_clk(5);
    check("lit_off", 16'(lit), 16'h0);
`ifdef LED_PANEL_RX_BLANK_STATS_EN
    check("on_cycles_before", on_cycles, 16'd100);
`endif

    arst = 1'b1;
    fd = 0;
    for (int i = 0; i < 8; i++) begin
      wait_clk(1);
      if (frame_done === 1'b1) fd++;
    end
    check("frame_done_pulses", 16'(fd), 16'h1);
    check("arst_row_addr", 16'(row_addr), 16'h0);
`ifdef LED_PANEL_RX_BLANK_STATS_EN
    check("on_cycles_after", on_cycles, 16'd0);
`endif
    mrow = 0;
    arst = 1'b0;
    wait_clk(4);

    arst = 1'b1;
    fd = 0;
    for (int i = 0; i < 8; i++) begin
      wait_clk(1);
      if (frame_done === 1'b1) fd++;
    end
    check("frame_done_empty", 16'(fd), 16'h0);
    arst = 1'b0;
    wait_clk(4);

    fill_row(1);
    fill_row(2);
    fill_row(3);
    run_reads();

    // Row address wrap, then aclk and arst rising together at row 2
    aclk_pulse();
    aclk_pulse();
    aclk_pulse();
    check("row_addr_at_3", 16'(row_addr), 16'h3);
    aclk_pulse();
    check("row_addr_wrap", 16'(row_addr), 16'h0);
    aclk_pulse();
    aclk_pulse();
    check("row_addr_at_2", 16'(row_addr), 16'h2);
    aclk = 1'b1;
    arst = 1'b1;
    wait_clk(4);
    check("aclk_arst_same", 16'(row_addr), 16'h0);
    aclk = 1'b0;
    arst = 1'b0;
    wait_clk(4);
    check("aclk_arst_after", 16'(row_addr), 16'h0);
    mrow = 0;

    // Reset in the middle of a row
    shift_bits(7, 10);
    do_reset();
    check("midrow_reset_err", 16'(err), 16'h0);
    shift_bits(2, 32);
    latch_rdw();
    check("after_reset_row_err", 16'(err), 16'h0);
    fill_row(0);
    run_reads();

    // Short row sets a sticky error
    shift_bits(5, 31);
    latch_pulse();
    check("err_short_row", 16'(err), 16'h1);
    shift_bits(6, 32);
    latch_pulse();
    check("err_sticky", 16'(err), 16'h1);
    do_reset();
    check("err_cleared", 16'(err), 16'h0);

    latch_pulse();
    check("err_empty_latch", 16'(err), 16'h1);
    do_reset();
    check("err_cleared2", 16'(err), 16'h0);

    // 32nd sclk edge and latch arriving together
    shift_bits(8, 31);
    rgb_in = pat(8, 31);
    sclk   = 1'b0;
    wait_clk(3);
    sclk   = 1'b1;
    latch  = 1'b1;
    model_shift(pat(8, 31));
    wait_clk(4);
    latch  = 1'b0;
    wait_clk(4);
    model_write();
    check("same_cycle_err", 16'(err), 16'h0);
    fill_row(0);
    run_reads();

    wait_clk(5);
    check("scoreboard_drained", 16'(sb.size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
